write_manager: RTL
==================

# write_manager

Per-channel writer into the event ring-buffer RAM, one instance per ADC input (16 in the OFC). On an accepted trigger it writes HALF_PACKAGE_LENGTH consecutive ADC samples at the channel's current ring slot and pulses `w_complete`. `w_complete` feeds the matching bit of the read manager's `w_complete[15:0]`. The block tracks ring occupancy from the read manager's `n_read` count, so it never overwrites an unread event.

## Interface
Parameters:
- `DATA_WIDTH`, 16: ADC sample width.

Ports:
- `clk`  in  1: system clock.
- `live_rising`  in  1: reset, synchronous, active-high.
- `trigger`  in  1: event accept request, level sampled each cycle.
- `adc_data`  in  DATA_WIDTH: ADC sample stream, one sample per clock.
- `TRIG_DELAY`  in  8: cycles between trigger and first captured sample.
- `HALF_PACKAGE_LENGTH`  in  10: samples per event; must be the same value given to the reader.
- `MEMORY_DEPTH`  in  15: ring size in words; must be the same value given to the reader.
- `n_read`  in  16: events released by the read manager.
- `wen`  out  1: RAM write enable.
- `waddr`  out  15: RAM write address.
- `wdata`  out  DATA_WIDTH: RAM write data.
- `w_complete`  out  1: one-cycle pulse when an event is fully written.
- `busy`  out  1: high in any state other than IDLE.
- `overflow`  out  1: sticky flag, set by the first dropped trigger.
- `n_drop`  out  16: count of dropped triggers, saturating at 0xFFFF.

## Operation
- Internal state:
  - `init_addr[14:0]`: ring slot for the next event.
  - `used[15:0]`: words reserved, not yet read.
  - `n_read_d`: `n_read` delayed by one cycle.
  - `dly_cnt[7:0]`, `cnt[9:0]`.
- FSM states: IDLE, DELAY, WRITE, DONE.
- IDLE, on `trigger`=1:
  - Accept if `HALF_PACKAGE_LENGTH`!=0 and `used + HALF_PACKAGE_LENGTH <= MEMORY_DEPTH`, using a 16-bit compare.
  - On accept: `used += HALF_PACKAGE_LENGTH` (space is reserved at accept); `waddr <= init_addr`; `dly_cnt <= 0`.
  - Next state is DELAY if `TRIG_DELAY`>0, otherwise WRITE.
  - If `used` would exceed `MEMORY_DEPTH`: drop the trigger, set `overflow`, `n_drop++` (saturating), stay in IDLE.
  - If `HALF_PACKAGE_LENGTH`=0: ignore the trigger. No drop is counted and no `w_complete` is issued.
- DELAY: increment `dly_cnt`. Enter WRITE when `dly_cnt == TRIG_DELAY-1`.
- WRITE:
  - `wen`=1 for exactly `HALF_PACKAGE_LENGTH` cycles.
  - After each write, `waddr <= (waddr < MEMORY_DEPTH-1) ? waddr+1 : 0`.
  - `cnt` counts writes. After the last write, go to DONE.
- DONE (one cycle):
  - `w_complete`=1.
  - `init_addr <= init_addr + HALF_PACKAGE_LENGTH`, minus `MEMORY_DEPTH` if the sum is >= `MEMORY_DEPTH`. The sum is computed 16 bits wide, and this slot sequence must equal the reader's `init_addr` sequence.
  - Return to IDLE.
- `trigger` outside IDLE is ignored. It is not counted as a drop.
- Read release: when `n_read != n_read_d`, `used -= HALF_PACKAGE_LENGTH`. Compare this to the read manager, which increments `n_read` by at most 1 per cycle.
  - If an accept and a release occur in the same cycle, apply the net change: `used` is unchanged.
  - `used` never underflows; clamp at 0.
- `wdata` is `adc_data` registered once. It is valid in every cycle where `wen`=1.
- `live_rising` mid-event:
  - Abort immediately; nothing further is written and no `w_complete` is issued.
  - All state returns to reset values, including `used`=0 and `init_addr`=0, which matches the reader's reset.
- Configuration inputs are sampled live and must be held static while `live_rising` is low.

## Timing
- Reset values:
  - Outputs: `wen`=0, `waddr`=0, `wdata`=0, `w_complete`=0, `busy`=0, `overflow`=0, `n_drop`=0.
  - Internal: FSM=IDLE, `init_addr`=0, `used`=0, `n_read_d`=0.
- Trigger sampled high in IDLE at cycle T, with D=`TRIG_DELAY` and H=`HALF_PACKAGE_LENGTH`:
  - `busy` rises at T+1.
  - First `wen` is at T+1+D, with `wdata` = `adc_data` from cycle T+D.
  - Last `wen` is at T+D+H.
  - `w_complete` pulses at T+1+D+H.
  - IDLE at T+2+D+H, so the next trigger can be accepted at T+2+D+H.
- The read manager's timeout window is 1000 clocks across channels. Valid configurations therefore require D+H+2 < 1000 plus the spread in inter-channel trigger skew.
- `overflow` and `n_drop` update the cycle after the dropped trigger.

## Test plan
- Reset, then `MEMORY_DEPTH`=64, H=8, D=0, one trigger at T, with `adc_data` a counter:
  - `wen` at T+1..T+8, `waddr` 0..7, `wdata` equal to the counter values from T..T+7.
  - `w_complete` at T+9; the next event starts at address 8.
- Wrap-around: `MEMORY_DEPTH`=20, H=8, `n_read` pulsed after each event:
  - The third event writes addresses 16,17,18,19,0,1,2,3.
  - The fourth event starts at 4.
- Full: `MEMORY_DEPTH`=32, H=8, `n_read` held at 0, five triggers:
  - Four events complete.
  - The fifth is dropped: `overflow`=1, `n_drop`=1, no `wen`.
  - Increment `n_read` once, then trigger: the event is accepted at address 0.
- Delay and busy: D=5, H=4, a second trigger asserted during WRITE:
  - First `wen` at T+6.
  - The second trigger is ignored: `n_drop`=0, exactly one `w_complete`.
- Simultaneous release: accept a trigger in the same cycle `n_read` increments, with `used`=24 of 32 and H=8:
  - The trigger is accepted.
  - `used` stays at 24.
- `live_rising` asserted at the third `wen` of an H=8 event:
  - The next cycle shows `wen`=0, `waddr`=0 and no `w_complete`.
  - The next event writes from address 0.

Source files
------------

// File: rtl/write_manager.sv
// Per-channel event writer into the shared ring-buffer RAM: captures HALF_PACKAGE_LENGTH
// samples per accepted trigger and tracks ring occupancy against the reader's release count.
module write_manager #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  live_rising,
  input  logic                  trigger,
  input  logic [DATA_WIDTH-1:0] adc_data,
  input  logic [7:0]            TRIG_DELAY,
  input  logic [9:0]            HALF_PACKAGE_LENGTH,
  input  logic [14:0]           MEMORY_DEPTH,
  input  logic [15:0]           n_read,
  output logic                  wen,
  output logic [14:0]           waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  w_complete,
  output logic                  busy,
  output logic                  overflow,
  output logic [15:0]           n_drop
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [14:0]             init_addr_q, init_addr_d;
  logic [15:0]             used_q, used_d;
  logic [15:0]             n_read_d_q;
  logic [7:0]              dly_cnt_q, dly_cnt_d;
  logic [9:0]              cnt_q, cnt_d;
  logic [14:0]             waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    wen_q, wen_d;
  logic                    w_complete_q, w_complete_d;
  logic                    busy_q, busy_d;
  logic                    overflow_q, overflow_d;
  logic [15:0]             n_drop_q, n_drop_d;

  logic [15:0] hpl16;
  logic [15:0] md16;
  logic        trig_fire;
  logic        fits;
  logic        accept;
  logic        drop;
  logic        release_ev;
  logic [15:0] used_inc;
  logic [15:0] init_sum;
  logic [15:0] init_next;

  assign hpl16      = {6'd0, HALF_PACKAGE_LENGTH};
  assign md16       = {1'b0, MEMORY_DEPTH};
  // A zero-length event request is silently ignored, never counted as a drop.
  assign trig_fire  = (state_q == IDLE) && trigger && (HALF_PACKAGE_LENGTH != 10'd0);
  assign fits       = (used_q + hpl16) <= md16;
  assign accept     = trig_fire && fits;
  assign drop       = trig_fire && !fits;
  assign release_ev = (n_read != n_read_d_q);
  assign used_inc   = used_q + (accept ? hpl16 : 16'd0);
  assign init_sum   = {1'b0, init_addr_q} + hpl16;
  assign init_next  = (init_sum >= md16) ? (init_sum - md16) : init_sum;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (TRIG_DELAY != 8'd0) ? DELAY : WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      DELAY: begin
        if (dly_cnt_q == (TRIG_DELAY - 8'd1)) begin
          state_d = WRITE;
        end else begin
          state_d = DELAY;
        end
      end
      WRITE: begin
        if (cnt_q == (HALF_PACKAGE_LENGTH - 10'd1)) begin
          state_d = DONE;
        end else begin
          state_d = WRITE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dly_cnt_d   = dly_cnt_q;
    cnt_d       = cnt_q;
    waddr_d     = waddr_q;
    init_addr_d = init_addr_q;
    case (state_q)
      IDLE: begin
        dly_cnt_d = 8'd0;
        cnt_d     = 10'd0;
        if (accept) begin
          waddr_d = init_addr_q;
        end else begin
          waddr_d = waddr_q;
        end
      end
      DELAY: dly_cnt_d = dly_cnt_q + 8'd1;
      WRITE: begin
        cnt_d   = cnt_q + 10'd1;
        waddr_d = (waddr_q < (MEMORY_DEPTH - 15'd1)) ? (waddr_q + 15'd1) : 15'd0;
      end
      DONE:    init_addr_d = init_next[14:0];
      default: init_addr_d = init_addr_q;
    endcase

    // Reservation happens at accept; a same-cycle release cancels it out.
    if (release_ev) begin
      used_d = (used_inc >= hpl16) ? (used_inc - hpl16) : 16'd0;
    end else begin
      used_d = used_inc;
    end

    if (drop) begin
      overflow_d = 1'b1;
      n_drop_d   = (n_drop_q != 16'hFFFF) ? (n_drop_q + 16'd1) : n_drop_q;
    end else begin
      overflow_d = overflow_q;
      n_drop_d   = n_drop_q;
    end
  end

  always_comb begin
    wen_d        = (state_d == WRITE);
    w_complete_d = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (live_rising) begin
      state_q      <= IDLE;
      init_addr_q  <= 15'd0;
      used_q       <= 16'd0;
      n_read_d_q   <= 16'd0;
      dly_cnt_q    <= 8'd0;
      cnt_q        <= 10'd0;
      waddr_q      <= 15'd0;
      wdata_q      <= '0;
      wen_q        <= 1'b0;
      w_complete_q <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      n_drop_q     <= 16'd0;
    end else begin
      state_q      <= state_d;
      init_addr_q  <= init_addr_d;
      used_q       <= used_d;
      n_read_d_q   <= n_read;
      dly_cnt_q    <= dly_cnt_d;
      cnt_q        <= cnt_d;
      waddr_q      <= waddr_d;
      wdata_q      <= adc_data;
      wen_q        <= wen_d;
      w_complete_q <= w_complete_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      n_drop_q     <= n_drop_d;
    end
  end

  assign wen        = wen_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign w_complete = w_complete_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign n_drop     = n_drop_q;

endmodule
